// File: rtl/dual_port_bram_be.sv
// True-dual-port RAM with byte enables, selectable read-during-write, 1/2-cycle read pipeline,
// same-address collision flag and an optional post-reset zero-fill.
module dual_port_bram_be #(
    parameter int DATA           = 64,
    parameter int ADDR           = 10,
    parameter int LATENCY        = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    output logic              collision,
    input  logic              a_req_en,
    input  logic [DATA/8-1:0] a_req_writeEn,
    input  logic [ADDR-1:0]   a_req_addr,
    input  logic [DATA-1:0]   a_req_writeData,
    output logic              a_rsp_valid,
    output logic [DATA-1:0]   a_rsp_readData,
    input  logic              b_req_en,
    input  logic [DATA/8-1:0] b_req_writeEn,
    input  logic [ADDR-1:0]   b_req_addr,
    input  logic [DATA-1:0]   b_req_writeData,
    output logic              b_rsp_valid,
    output logic [DATA-1:0]   b_rsp_readData
);
    localparam int NB = DATA / 8;

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR-1:0]   ptr;
    logic              clr_en;
    logic [DATA-1:0]   mem [2**ADDR];

    logic              a_acc, b_acc, a_wr, b_wr;
    logic [DATA-1:0]   a_s1, b_s1;
    logic              a_v1, b_v1;
    logic [DATA-1:0]   a_d1, b_d1;

    function automatic logic [DATA-1:0] merge(input logic [DATA-1:0] old_w,
                                              input logic [DATA-1:0] new_w,
                                              input logic [NB-1:0]   be);
        logic [DATA-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en) ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && ptr == {ADDR{1'b1}}) state_nxt = READY;
    end

    always_comb begin
        init_busy = (state == CLEAR);
        clr_en    = (state == CLEAR);
    end

    assign a_acc = a_req_en & ~init_busy;
    assign b_acc = b_req_en & ~init_busy;
    assign a_wr  = |a_req_writeEn;
    assign b_wr  = |b_req_writeEn;

    // Port B's byte writes are issued last so it wins bytes enabled on both ports.
    always_ff @(posedge clock) begin
        if (clr_en) mem[ptr] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (a_acc && a_req_writeEn[i]) mem[a_req_addr][8*i +: 8] <= a_req_writeData[8*i +: 8];
            if (b_acc && b_req_writeEn[i]) mem[b_req_addr][8*i +: 8] <= b_req_writeData[8*i +: 8];
        end
    end

    // Cross-port reads always see the pre-edge word; only the own port can see its merge.
    always_comb begin
        a_s1 = mem[a_req_addr];
        b_s1 = mem[b_req_addr];
        if (RDW_MODE == 0 && a_wr) a_s1 = merge(mem[a_req_addr], a_req_writeData, a_req_writeEn);
        if (RDW_MODE == 0 && b_wr) b_s1 = merge(mem[b_req_addr], b_req_writeData, b_req_writeEn);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_v1      <= 1'b0;
            b_v1      <= 1'b0;
            a_d1      <= '0;
            b_d1      <= '0;
            collision <= 1'b0;
        end else begin
            a_v1      <= a_acc;
            b_v1      <= b_acc;
            if (a_acc) a_d1 <= a_s1;
            if (b_acc) b_d1 <= b_s1;
            collision <= a_acc & b_acc & (a_req_addr == b_req_addr) & (a_wr | b_wr);
        end
    end

    generate
        if (LATENCY == 2) begin : gen_lat2
            logic            a_v2, b_v2;
            logic [DATA-1:0] a_d2, b_d2;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                    a_d2 <= '0;
                    b_d2 <= '0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) a_d2 <= a_d1;
                    if (b_v1) b_d2 <= b_d1;
                end
            end
            assign a_rsp_valid    = a_v2;
            assign b_rsp_valid    = b_v2;
            assign a_rsp_readData = a_d2;
            assign b_rsp_readData = b_d2;
        end else begin : gen_lat1
            assign a_rsp_valid    = a_v1;
            assign b_rsp_valid    = b_v1;
            assign a_rsp_readData = a_d1;
            assign b_rsp_readData = b_d1;
        end
    endgenerate
endmodule
